// File: rtl/mx_int8_to_fp32_dequant.sv
// mx_int8_to_fp32_dequant
// Buffers one MXINT8 block (BLK_SIZE INT8 elements + shared E8M0 scale) and
// streams it out as FP32, LANES elements per beat, with ready/valid on both sides.
// Optional build macro: SUBNORMAL_EN. When it is defined, underflowing elements
// become exact FP32 subnormals. When it is undefined, they flush to signed zero.
module mx_int8_to_fp32_dequant #(
  parameter  int BLK_SIZE = 32,
  parameter  int LANES    = 4,
  localparam int BEATS    = BLK_SIZE / LANES,
  localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_scale,
  input  logic [8*BLK_SIZE-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_data,
  output logic                  out_last,
  output logic [BW-1:0]         out_beat
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_t                state;
  logic [BW-1:0]         beat_q;
  logic [7:0]            scale_q;
  logic [8*BLK_SIZE-1:0] data_q;

  // Convert one INT8 element under scale x. Every normal result is exact, so no rounding is needed.
  function automatic logic [31:0] conv(input logic [7:0] q, input logic [7:0] x);
    logic              s;
    logic [8:0]        m;
    logic [8:0]        mant;
    logic [2:0]        p;
    logic signed [9:0] e;
    logic [22:0]       frac;
    s = q[7];
    // A 9-bit negate lets q = -128 map to magnitude 128.
    m = s ? 9'(-$signed({q[7], q})) : {1'b0, q};
    p = 3'd0;
    for (int i = 0; i < 8; i++)
      if (m[i]) p = 3'(i);
    mant    = m;
    mant[p] = 1'b0;
    frac    = 23'(mant) << (5'd23 - {2'b00, p});
    e       = $signed({2'b00, x}) + $signed({7'b0, p}) - 10'sd6;
    if (x == 8'hFF)
      conv = 32'h7FC0_0000;
    else if (q == 8'h00)
      conv = 32'h0000_0000;
    else if (e >= 10'sd255)
      conv = {s, 8'hFF, 23'h0};
    else if (e >= 10'sd1)
      conv = {s, e[7:0], frac};
    else begin
`ifdef SUBNORMAL_EN
      conv = {s, 8'h00, 23'(m) << (x + 8'd16)};
`else
      conv = {s, 31'b0};
`endif
    end
  endfunction

  // Accept a new block when idle, or on the final beat as it is consumed.
  assign in_ready = (state == IDLE) || ((beat_q == LAST_BEAT) && out_ready);
  assign out_beat = beat_q;

  // Convert the lanes of the current beat from the buffer; the output is zero while no beat is valid.
  always_comb begin
    out_data = '0;
    for (int j = 0; j < LANES; j++)
      out_data[32*j +: 32] = out_valid ?
        conv(data_q[8*(int'(beat_q)*LANES + j) +: 8], scale_q) : 32'h0;
  end

  // Block capture and beat sequencing, with a back-to-back reload on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      beat_q    <= '0;
      scale_q   <= '0;
      data_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            scale_q   <= in_scale;
            data_q    <= in_data;
            state     <= EMIT;
            out_valid <= 1'b1;
            beat_q    <= '0;
            out_last  <= (BEATS == 1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (beat_q == LAST_BEAT) begin
              if (in_valid) begin
                scale_q  <= in_scale;
                data_q   <= in_data;
                beat_q   <= '0;
                out_last <= (BEATS == 1);
              end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                beat_q    <= '0;
              end
            end else begin
              beat_q   <= beat_q + BW'(1);
              out_last <= ((beat_q + BW'(1)) == LAST_BEAT);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mx_int8_to_fp32_dequant.sv
// Testbench for mx_int8_to_fp32_dequant: a reference model computes each element
// through real arithmetic (q * 2^(X-133)) and re-encodes the IEEE double as FP32.
module tb_mx_int8_to_fp32_dequant;

  localparam int BLK   = 32;
  localparam int LANES = 4;
  localparam int BEATS = BLK / LANES;
  localparam int BW    = $clog2(BEATS);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [7:0]           in_scale = 8'h00;
  logic [8*BLK-1:0]     in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [32*LANES-1:0]  out_data;
  logic                 out_last;
  logic [BW-1:0]        out_beat;

  int total = 0;
  int passed = 0;
  int rdy_mode = 0;
  int consumed = 0;

  typedef struct {
    logic [32*LANES-1:0] data;
    int                  beat;
  } exp_t;
  exp_t expq[$];

  mx_int8_to_fp32_dequant dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_scale(in_scale), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_beat(out_beat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Reference: exact value as a double, then repacked into FP32 fields.
  function automatic logic [31:0] model_elem(input logic [7:0] q, input logic [7:0] x);
    int          qi;
    int          e;
    int          ef;
    int          mag;
    real         r;
    logic [63:0] b;
    qi = int'($signed(q));
    if (x == 8'hFF) return 32'h7FC0_0000;
    if (qi == 0) return 32'h0;
    r = qi;
    e = int'(x) - 133;
    if (e > 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else       for (int i = 0; i < -e; i++) r = r / 2.0;
    b  = $realtobits(r);
    ef = int'(b[62:52]) - 1023 + 127;
    if (ef >= 255) return {b[63], 8'hFF, 23'h0};
    if (ef >= 1)   return {b[63], 8'(ef), b[51:29]};
`ifdef SUBNORMAL_EN
    mag = (qi < 0) ? -qi : qi;
    return {b[63], 8'h00, 23'(mag << (int'(x) + 16))};
`else
    mag = 0;
    return {b[63], 31'b0} | 32'(mag);
`endif
  endfunction

  function automatic logic [32*LANES-1:0] model_beat(input logic [7:0] x, input logic [8*BLK-1:0] d, input int bt);
    logic [32*LANES-1:0] v;
    v = '0;
    for (int j = 0; j < LANES; j++) v[32*j +: 32] = model_elem(d[8*(bt*LANES+j) +: 8], x);
    return v;
  endfunction

  // Scoreboard: every valid beat must match the front of the expected queue.
  always @(negedge clk) begin
    if (!rst_n) expq.delete();
    else begin
      if (out_valid) begin
        if (expq.size() == 0) check("unexpected_beat", 128'(out_valid), 128'(0));
        else begin
          check("beat_data", 128'(out_data), 128'(expq[0].data));
          check("beat_idx_last", 128'({out_beat, out_last}),
                128'({BW'(expq[0].beat), expq[0].beat == BEATS-1}));
          if (out_ready) begin void'(expq.pop_front()); consumed++; end
        end
      end
      if (in_valid && in_ready)
        for (int b = 0; b < BEATS; b++) expq.push_back('{model_beat(in_scale, in_data, b), b});
    end
  end

  // out_ready driver: 0 = always ready, 1 = pattern 1,0,0 repeating.
  always @(posedge clk) begin : rdy_gen
    int ph;
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else begin
      out_ready = (ph == 0);
      ph = (ph + 1) % 3;
    end
  end

  task automatic send_block(input logic [7:0] x, input logic [8*BLK-1:0] d);
    bit ok;
    @(posedge clk); #1;
    in_valid = 1'b1; in_scale = x; in_data = d;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", 128'(0), 128'(1));
  endtask

  function automatic logic [8*BLK-1:0] pattern(input int seed);
    logic [8*BLK-1:0] d;
    for (int i = 0; i < BLK; i++) d[8*i +: 8] = 8'(i * 37 + seed * 11 - 90);
    return d;
  endfunction

  initial begin
    logic [8*BLK-1:0] d;
    bit ok;

    // Model pinned against hand-computed encodings.
    check("model_64_x127",   128'(model_elem(8'd64, 8'd127)),  128'(32'h3F80_0000));
    check("model_m128_x127", 128'(model_elem(8'h80, 8'd127)),  128'(32'hC000_0000));
    check("model_1_x127",    128'(model_elem(8'd1, 8'd127)),   128'(32'h3C80_0000));
    check("model_127_x254",  128'(model_elem(8'd127, 8'd254)), 128'(32'h7F7E_0000));
    check("model_m128_x254", 128'(model_elem(8'h80, 8'd254)),  128'(32'hFF80_0000));

    #1;
    check("rst_outputs", 128'({in_ready, out_valid, out_last, out_beat, out_data}),
          128'({1'b1, 1'b0, 1'b0, BW'(0), 128'h0}));
    #20 rst_n = 1'b1;

    // Basic conversion.
    d = pattern(1);
    d[7:0] = 8'd64; d[15:8] = 8'h80; d[23:16] = 8'd1; d[31:24] = 8'd0;
    send_block(8'd127, d);
    check("t1_beat0", 128'(out_data),
          {32'h0000_0000, 32'h3C80_0000, 32'hC000_0000, 32'h3F80_0000});
    drain();

    // NaN scale.
    send_block(8'hFF, pattern(2));
    check("t2_nan_lane0", 128'(out_data[31:0]), 128'(32'h7FC0_0000));
    drain();

    // Top of range.
    d = pattern(3);
    d[7:0] = 8'd127; d[15:8] = 8'h80;
    send_block(8'd254, d);
    check("t3_max", 128'(out_data[63:0]), 128'({32'hFF80_0000, 32'h7F7E_0000}));
    drain();

    // Bottom of range.
    d = pattern(4);
    d[7:0] = 8'd1; d[15:8] = 8'hFF;
    send_block(8'd0, d);
`ifdef SUBNORMAL_EN
    check("t4_underflow", 128'(out_data[63:0]), 128'({32'h8001_0000, 32'h0001_0000}));
`else
    check("t4_underflow", 128'(out_data[63:0]), 128'({32'h8000_0000, 32'h0000_0000}));
`endif
    drain();

    // A general mid-range scale.
    send_block(8'd130, pattern(5));
    drain();

    // Two blocks back to back under backpressure.
    rdy_mode = 1;
    consumed = 0;
    send_block(8'd120, pattern(6));
    send_block(8'd140, pattern(7));
    check("t5_no_bubble", 128'({out_valid, out_beat}), 128'({1'b1, BW'(0)}));
    drain();
    check("t5_beat_count", 128'(consumed), 128'(2*BEATS));
    rdy_mode = 0;

    // Reset in the middle of a block.
    send_block(8'd127, pattern(8));
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid && out_beat == BW'(3)) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check("t6_reach_beat3", 128'(0), 128'(1));
    #2 rst_n = 1'b0;
    #1 check("t6_rst_async", 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_after_rst", 128'({in_ready, out_valid, out_last, out_beat}),
          128'({1'b1, 1'b0, 1'b0, BW'(0)}));
    send_block(8'd125, pattern(9));
    check("t6_restart", 128'({out_valid, out_beat}), 128'({1'b1, BW'(0)}));
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mx_int8_to_fp32_dequant.md
Name: mx_int8_to_fp32_dequant

Overview:
- Inverse of the FP32→MXINT8 quantizer path: accepts one MXINT8 block (BLK_SIZE two's-complement INT8 elements plus one shared E8M0 scale) and streams it back out as FP32 values, LANES elements per beat.
- Sits on the read side of the MX datapath, feeding FP32 consumers.
- Ready/valid on both sides. The block is buffered internally so the producer is released immediately.

Parameters:
- BLK_SIZE, 32, elements per MX block; must be a multiple of LANES.
- LANES, 4, FP32 elements emitted per output beat; BEATS = BLK_SIZE/LANES.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  block presented
- in_ready  out  1  block can be accepted
- in_scale  in  8  shared E8M0 scale X; 0xFF = NaN
- in_data  in  8*BLK_SIZE  element i at bits [8i+7:8i]
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  32*LANES  lane j at bits [32j+31:32j]
- out_last  out  1  final beat of block
- out_beat  out  clog2(BEATS)  beat index 0..BEATS-1

Behaviour:
- Clock and reset: one clock domain. Asynchronous active-low reset (rst_n) on all flops.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_last=0, out_beat=0, out_data=0. The buffer contents are don't-care.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture in_scale and in_data into the buffer and go to EMIT with beat=0.
  - EMIT: out_valid=1. A beat is consumed when out_valid&&out_ready.
    - Consumed beat with beat<BEATS-1: beat increments.
    - Consumed beat with beat=BEATS-1: go to IDLE.
- Back-to-back blocks: in_ready is also 1 in EMIT when beat=BEATS-1 and out_ready=1. A block accepted that cycle reloads the buffer, and the FSM stays in EMIT with beat=0 with no bubble.
- Latency: a block accepted at edge T gives beat 0 valid after edge T (register output). One beat per cycle under full throughput.
- Backpressure: out_data, out_beat and out_last hold stable while out_valid&&!out_ready.
- Ordering: beat b, lane j carries element b*LANES+j. out_last=1 exactly when out_beat=BEATS-1.
- Per-element conversion (q = INT8, X = scale; value = q * 2^-6 * 2^(X-127)):
  - X=0xFF: output 0x7FC00000 (quiet NaN) for every element.
  - q=0: output 0x00000000.
  - Otherwise:
    - s = sign(q); m = |q|, range 1..128 (q=-128 gives m=128, using a 9-bit magnitude).
    - p = index of the leading one of m, range 0..7.
    - Biased exponent E = X + p - 6, computed signed with at least 10 bits.
    - 1 <= E <= 254: output {s, E[7:0], (m with its leading one removed) << (23-p)}. The result is exact, so no rounding.
    - E >= 255 (only X=254, q=-128): ±Inf, i.e. {s, 0xFF, 0}.
    - E <= 0: underflow; behaviour set by SUBNORMAL_EN (see Optional Feature).
- Reset asserted mid-block: the block is dropped and the FSM returns to IDLE. No partial beats appear after rst_n deasserts.
- in_valid while in_ready=0 is ignored; the producer must hold the block.

Optional Feature:
- Macro: SUBNORMAL_EN.
- Defined: an underflow element is output as the exact FP32 subnormal {s, 0x00, m << (X+16)}. The 23-bit field fits because E<=0 implies m < 2^(7-X).
- Undefined: an underflow element is flushed to signed zero, {s, 31'b0}.

Test Plan:
- X=127, elements 64, -128, 1, 0 in lanes 0..3 → beat 0 = 0x3F800000, 0xC0000000, 0x3C800000, 0x00000000.
- X=0xFF, arbitrary elements → all BEATS beats carry 0x7FC00000; out_last only on beat 7.
- X=254, q=127 → 0x7F7E0000; X=254, q=-128 → 0xFF800000 (-Inf).
- X=0, q=1 → 0x00000000 without SUBNORMAL_EN, 0x00010000 with it; X=0, q=-1 → 0x80000000 / 0x80010000.
- Two blocks with out_ready toggling 1,0,0,1,… → data held stable while stalled; second block accepted on the last beat of the first with no idle cycle; 16 beats total, in order.
- rst_n pulsed low during beat 3 → out_valid falls immediately; after release in_ready=1, out_valid=0, and a new block starts at beat 0.
